bs_mac_sequencer: RTL and testbench
===================================

# bs_mac_sequencer

Sequencer for the bit-serial MAC datapath. Given per-job activation and weight precisions and a word count, it steps the activation and weight bit indices, drives the accumulator's enable and clear strobes, and reports the shift amount and sign-correction flag for each bit pair. It also flags each completed output word. It sits between the layer controller (start/ready/done handshake) and the bit-serial PE array, replacing free-running strobe counters with a precision-aware schedule.

## Interface
- PREC_W, 4: width of the precision fields; max precision is 2^PREC_W bits.
- WCNT_W, 8: width of the word-count field.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- a_prec_m1  in  PREC_W  activation bits minus 1; latched on accepted start.
- w_prec_m1  in  PREC_W  weight bits minus 1; latched on accepted start.
- nwords_m1  in  WCNT_W  output words minus 1; latched on accepted start.
- signed_mode  in  1  two's-complement operands; latched on accepted start.
- stall  in  1  operand bits not available this cycle; freezes the schedule.
- abort  in  1  synchronous job cancel.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle pulse at job end.
- a_idx  out  PREC_W  current activation bit index.
- w_idx  out  PREC_W  current weight bit index.
- shift_amt  out  PREC_W+1  a_idx + w_idx, zero-extended; no overflow.
- acc_en  out  1  accumulate this cycle.
- acc_clr  out  1  load the product instead of adding it (first pair of a word).
- neg  out  1  subtract the partial product.
- word_last  out  1  last bit pair of the current word.
- out_valid  out  1  accumulator holds a finished word.

## Operation
- States are IDLE, RUN and DONE.
- Reset values: state=IDLE, indices=0, word counter=0, out_valid=0, done=0, latched config=0. So ready=1, all other outputs 0.
- **IDLE**
  - start=1 latches the config, clears the counters and moves to RUN.
  - start in RUN or DONE is ignored.
- **RUN, each non-stalled cycle**
  - acc_en=1.
  - acc_clr=1 iff a_idx=0 and w_idx=0.
  - neg = signed_mode & ((a_idx==a_prec_m1) ^ (w_idx==w_prec_m1)).
  - word_last=1 iff a_idx==a_prec_m1 and w_idx==w_prec_m1.
- **Iteration order**
  - a_idx is the inner loop: it increments and wraps to 0 after a_prec_m1.
  - w_idx increments on each a_idx wrap and wraps to 0 after w_prec_m1.
  - On a word_last cycle the word counter increments. If the counter equals nwords_m1 on that cycle, the next state is DONE; otherwise the next word starts with no bubble.
- **Stall in RUN**
  - Counters and state hold.
  - acc_en=0, acc_clr=0, word_last=0, neg=0.
  - a_idx, w_idx and shift_amt still show the held values.
- **out_valid**
  - Registered. High for exactly one cycle, in the cycle after each non-stalled word_last cycle.
  - It pulses even if that following cycle is stalled.
- **DONE** lasts one cycle with done=1 and out_valid=1, then returns to IDLE.
- **Abort** in RUN or DONE: the next state is IDLE and counters clear. out_valid and done are not asserted at the next edge, even if abort coincides with word_last. Abort in IDLE has no effect.
- **Precision 1**
  - a_prec_m1=0 and w_prec_m1=0 give one pair per word; acc_clr and word_last are both high every cycle.
  - Under signed_mode, neg=0 when both indices are the MSB, because the product of two sign bits is positive.
- rst_n deassertion mid-job aborts it silently; the block comes up in IDLE.

## Timing
- Start accepted at edge T: busy=1 and the first pair (acc_clr=1) appear in cycle T+1.
- Cycles per word = (a_prec_m1+1)*(w_prec_m1+1), plus stall cycles.
- Total RUN cycles = (nwords_m1+1) × cycles per word, plus stalls; DONE adds 1 cycle.
- Next start can be accepted in the cycle after DONE.
- All outputs are decodes of registered state; only the stall gating is combinational (stall to acc_en/acc_clr/word_last/neg).

## Test plan
- **Unsigned, 2×3 bits, two words** (a_prec_m1=1, w_prec_m1=2, nwords_m1=1, no stall)
  - (a_idx,w_idx) sequence per word: (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
  - shift_amt sequence: 0,1,1,2,2,3.
  - acc_clr in RUN cycles 1 and 7; word_last in cycles 6 and 12.
  - out_valid in cycle 7 and in cycle 13 (DONE, with done=1); ready=1 in cycle 14.
- **Signed 4×4 bits** (nwords_m1=0)
  - neg=1 exactly for pairs (3,0),(3,1),(3,2),(0,3),(1,3),(2,3); neg=0 at (3,3).
  - 16 RUN cycles, then DONE.
- **Stall** held for 3 cycles starting on the word_last cycle of word 0 (2×2 bits, two words)
  - word_last deasserts and indices hold at (1,1) for 3 cycles.
  - out_valid pulses once, in the cycle after word_last is released.
  - Job completes 3 cycles late.
- **1×1 bits, nwords_m1=3**
  - acc_en, acc_clr and word_last are high for 4 consecutive cycles.
  - out_valid is high for cycles 2–5; done is high in cycle 5.
- **Abort coinciding with word_last of the final word**
  - IDLE at the next edge; done and out_valid never assert; ready=1.
- **Corner stimuli**
  - start held high through a whole job: exactly one job runs, and a second starts the cycle after DONE.
  - rst_n pulsed low asynchronously mid-word: all outputs go to their reset values immediately.

Source files
------------

// File: rtl/bs_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// bs_mac_sequencer_if
//   Bundles the job handshake, job configuration, per-cycle control inputs
//   and the schedule outputs of the bit-serial MAC sequencer.
//
//   master : layer controller / PE-array side. It drives start, the config
//            fields, stall and abort, and observes the schedule.
//   slave  : the sequencer itself.
//
//   Signals
//     start        job request, honoured only while ready=1
//     a_prec_m1    activation precision minus 1
//     w_prec_m1    weight precision minus 1
//     nwords_m1    number of output words minus 1
//     signed_mode  operands are two's complement
//     stall        operand bits unavailable, freeze the schedule
//     abort        cancel the running job
//     ready/busy/done             job status
//     a_idx/w_idx/shift_amt       current bit pair and its weight
//     acc_en/acc_clr/neg          accumulator strobes
//     word_last/out_valid         word completion flags
// ---------------------------------------------------------------------------
interface bs_mac_sequencer_if #(
    parameter int PREC_W = 4,
    parameter int WCNT_W = 8
);
    logic              start;
    logic [PREC_W-1:0] a_prec_m1;
    logic [PREC_W-1:0] w_prec_m1;
    logic [WCNT_W-1:0] nwords_m1;
    logic              signed_mode;
    logic              stall;
    logic              abort;

    logic              ready;
    logic              busy;
    logic              done;
    logic [PREC_W-1:0] a_idx;
    logic [PREC_W-1:0] w_idx;
    logic [PREC_W:0]   shift_amt;
    logic              acc_en;
    logic              acc_clr;
    logic              neg;
    logic              word_last;
    logic              out_valid;

    modport master (
        output start, a_prec_m1, w_prec_m1, nwords_m1, signed_mode, stall, abort,
        input  ready, busy, done, a_idx, w_idx, shift_amt,
               acc_en, acc_clr, neg, word_last, out_valid
    );

    modport slave (
        input  start, a_prec_m1, w_prec_m1, nwords_m1, signed_mode, stall, abort,
        output ready, busy, done, a_idx, w_idx, shift_amt,
               acc_en, acc_clr, neg, word_last, out_valid
    );
endinterface

// File: rtl/bs_mac_sequencer.sv
// ---------------------------------------------------------------------------
// bs_mac_sequencer
//   Precision-aware schedule generator for the bit-serial MAC datapath.
//   For each output word it walks every (activation bit, weight bit) pair,
//   activation index innermost, and drives the accumulator strobes for it:
//   acc_en (accumulate), acc_clr (first pair of a word), neg (pair carries a
//   negative weight under two's complement) and word_last. out_valid pulses
//   the cycle after a word's last pair; done pulses once at job end.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    bs_mac_sequencer_if.slave (handshake, config, schedule outputs)
//
//   All outputs are decodes of registered state; only stall gates the
//   strobes combinationally.
// ---------------------------------------------------------------------------
module bs_mac_sequencer #(
    parameter int PREC_W = 4,
    parameter int WCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bs_mac_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PREC_W-1:0] a_idx_q, a_idx_d;
    logic [PREC_W-1:0] w_idx_q, w_idx_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [PREC_W-1:0] a_prec_q, a_prec_d;
    logic [PREC_W-1:0] w_prec_q, w_prec_d;
    logic [WCNT_W-1:0] nwords_q, nwords_d;
    logic              signed_q, signed_d;
    logic              out_valid_q, out_valid_d;

    logic a_last;
    logic w_last;
    logic pair_step;

    assign a_last    = (a_idx_q == a_prec_q);
    assign w_last    = (w_idx_q == w_prec_q);
    assign pair_step = (state_q == RUN) && !bus.stall;

    // State and schedule registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_idx_q     <= '0;
            w_idx_q     <= '0;
            wcnt_q      <= '0;
            a_prec_q    <= '0;
            w_prec_q    <= '0;
            nwords_q    <= '0;
            signed_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_idx_q     <= a_idx_d;
            w_idx_q     <= w_idx_d;
            wcnt_q      <= wcnt_d;
            a_prec_q    <= a_prec_d;
            w_prec_q    <= w_prec_d;
            nwords_q    <= nwords_d;
            signed_q    <= signed_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d     = state_q;
        a_idx_d     = a_idx_q;
        w_idx_d     = w_idx_q;
        wcnt_d      = wcnt_q;
        a_prec_d    = a_prec_q;
        w_prec_d    = w_prec_q;
        nwords_d    = nwords_q;
        signed_d    = signed_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_prec_d = bus.a_prec_m1;
                    w_prec_d = bus.w_prec_m1;
                    nwords_d = bus.nwords_m1;
                    signed_d = bus.signed_mode;
                    a_idx_d  = '0;
                    w_idx_d  = '0;
                    wcnt_d   = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                if (bus.abort) begin
                    // Cancel wins over a coincident word_last: no out_valid.
                    state_d = IDLE;
                    a_idx_d = '0;
                    w_idx_d = '0;
                    wcnt_d  = '0;
                end else if (!bus.stall) begin
                    out_valid_d = a_last && w_last;
                    if (a_last) begin
                        a_idx_d = '0;
                        if (w_last) begin
                            w_idx_d = '0;
                            if (wcnt_q == nwords_q) begin
                                wcnt_d  = '0;
                                state_d = DONE;
                            end else begin
                                wcnt_d = wcnt_q + WCNT_W'(1);
                            end
                        end else begin
                            w_idx_d = w_idx_q + PREC_W'(1);
                        end
                    end else begin
                        a_idx_d = a_idx_q + PREC_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                a_idx_d = '0;
                w_idx_d = '0;
                wcnt_d  = '0;
            end

            default: begin
                state_d = IDLE;
                a_idx_d = '0;
                w_idx_d = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    // Output decode
    assign bus.ready     = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.a_idx     = a_idx_q;
    assign bus.w_idx     = w_idx_q;
    assign bus.shift_amt = {1'b0, a_idx_q} + {1'b0, w_idx_q};
    assign bus.acc_en    = pair_step;
    assign bus.acc_clr   = pair_step && (a_idx_q == '0) && (w_idx_q == '0);
    assign bus.word_last = pair_step && a_last && w_last;
    // Exactly one operand at its sign bit gives a negatively weighted
    // partial product; both at the sign bit gives a positive one.
    assign bus.neg       = pair_step && signed_q && (a_last ^ w_last);
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bs_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bs_mac_sequencer
//   Scoreboard bench. Each job pushes its expected bit-pair schedule and
//   word completions into queues; a monitor on the falling edge pops and
//   compares whenever the DUT presents acc_en or out_valid.
// ---------------------------------------------------------------------------
module tb_bs_mac_sequencer;
    localparam int PREC_W = 4;
    localparam int WCNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bs_mac_sequencer_if #(.PREC_W(PREC_W), .WCNT_W(WCNT_W)) bus();

    bs_mac_sequencer #(.PREC_W(PREC_W), .WCNT_W(WCNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [PREC_W-1:0] a;
        logic [PREC_W-1:0] w;
        logic [PREC_W:0]   shift;
        logic              clr;
        logic              neg;
        logic              last;
    } pair_t;

    pair_t pair_q[$];
    bit    word_q[$];
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    rst_epoch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference schedule: every (a,w) bit pair of every word, a innermost.
    function automatic void push_job(input int ap, input int wp, input int n, input bit sgn);
        pair_t p;
        for (int wd = 0; wd <= n; wd++) begin
            for (int wi = 0; wi <= wp; wi++) begin
                for (int ai = 0; ai <= ap; ai++) begin
                    p.a     = PREC_W'(ai);
                    p.w     = PREC_W'(wi);
                    p.shift = (PREC_W+1)'(ai + wi);
                    p.clr   = (ai == 0) && (wi == 0);
                    p.neg   = sgn && ((ai == ap) != (wi == wp));
                    p.last  = (ai == ap) && (wi == wp);
                    pair_q.push_back(p);
                end
            end
            word_q.push_back(wd == n);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        pair_t p;
        bit    prev_wl;
        bit    wl_now;
        bit    last_word;
        int    seen_epoch;
        prev_wl    = 1'b0;
        seen_epoch = 0;
        forever begin
            @(negedge clk);
            if (rst_epoch != seen_epoch) begin
                prev_wl    = 1'b0;
                seen_epoch = rst_epoch;
            end
            if (rst_n) begin
                wl_now = 1'b0;
                chk("ready_vs_busy", bus.ready, !bus.busy);
                chk("shift_amt", bus.shift_amt, int'(bus.a_idx) + int'(bus.w_idx));
                chk("out_valid_timing", bus.out_valid, prev_wl);
                if (bus.out_valid) begin
                    chk("out_valid_has_word", word_q.size() > 0, 1);
                    if (word_q.size() > 0) begin
                        last_word = word_q.pop_front();
                        chk("done_on_last_word", bus.done, last_word);
                    end
                end else begin
                    chk("done_without_word", bus.done, 0);
                end
                if (bus.busy && !bus.done)
                    chk("acc_en_vs_stall", bus.acc_en, !bus.stall);
                if (bus.acc_en) begin
                    chk("pair_pending", pair_q.size() > 0, 1);
                    if (pair_q.size() > 0) begin
                        p = pair_q.pop_front();
                        chk("a_idx", bus.a_idx, p.a);
                        chk("w_idx", bus.w_idx, p.w);
                        chk("shift_exp", bus.shift_amt, p.shift);
                        chk("acc_clr", bus.acc_clr, p.clr);
                        chk("neg", bus.neg, p.neg);
                        chk("word_last", bus.word_last, p.last);
                        wl_now = p.last;
                    end
                end else begin
                    chk("gated_strobes", {bus.acc_clr, bus.word_last, bus.neg}, 0);
                    if (bus.busy && !bus.done && pair_q.size() > 0) begin
                        chk("held_a_idx", bus.a_idx, pair_q[0].a);
                        chk("held_w_idx", bus.w_idx, pair_q[0].w);
                    end
                    if (bus.ready) begin
                        chk("idle_a_idx", bus.a_idx, 0);
                        chk("idle_w_idx", bus.w_idx, 0);
                    end
                end
                prev_wl = wl_now && !bus.abort;
            end
        end
    end

    // smode: 0 no stall, 1 random stall, 2 three-cycle burst before pair stall_at.
    // abort_at: pair index on which abort is raised (-1 = never).
    task automatic run_job(input int ap, input int wp, input int n, input bit sgn,
                           input int smode, input int stall_at, input int abort_at,
                           input bit hold);
        int pairs, remaining, stalls, cycles, burst, idx;
        bit aborted;
        pairs = (ap + 1) * (wp + 1) * (n + 1);
        chk("ready_before_start", bus.ready, 1);
        bus.start       = 1'b1;
        bus.a_prec_m1   = PREC_W'(ap);
        bus.w_prec_m1   = PREC_W'(wp);
        bus.nwords_m1   = WCNT_W'(n);
        bus.signed_mode = sgn;
        push_job(ap, wp, n, sgn);
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        remaining = pairs;
        stalls    = 0;
        cycles    = 0;
        burst     = 0;
        aborted   = 1'b0;
        while (!bus.ready && cycles < 20000) begin
            cycles++;
            // Scramble the config inputs: the running job must use its latched copy.
            bus.a_prec_m1   = PREC_W'($urandom);
            bus.w_prec_m1   = PREC_W'($urandom);
            bus.nwords_m1   = WCNT_W'($urandom);
            bus.signed_mode = 1'($urandom);
            bus.stall = 1'b0;
            bus.abort = 1'b0;
            if (remaining > 0) begin
                idx = pairs - remaining;
                if (smode == 1) bus.stall = ($urandom_range(3) == 0);
                if (smode == 2 && idx == stall_at && burst < 3) begin
                    bus.stall = 1'b1;
                    burst++;
                end
                if (bus.stall) begin
                    stalls++;
                end else begin
                    if (idx == abort_at) begin
                        bus.abort = 1'b1;
                        aborted   = 1'b1;
                    end
                    remaining--;
                end
            end
            @(posedge clk); #1;
            if (aborted) break;
        end
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        chk("job_bounded", cycles < 20000, 1);
        if (aborted) begin
            chk("abort_to_idle", bus.ready, 1);
            chk("abort_no_done", bus.done, 0);
            pair_q.delete();
            word_q.delete();
        end else begin
            chk("job_cycles", cycles, pairs + stalls + 1);
        end
    endtask

    // Stimulus
    initial begin
        int ap, wp, n, pairs, ab;
        bus.start       = 1'b0;
        bus.a_prec_m1   = '0;
        bus.w_prec_m1   = '0;
        bus.nwords_m1   = '0;
        bus.signed_mode = 1'b0;
        bus.stall       = 1'b0;
        bus.abort       = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_strobes", {bus.acc_en, bus.acc_clr, bus.neg, bus.word_last}, 0);
        chk("rst_idx", {bus.a_idx, bus.w_idx, bus.shift_amt}, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_job(1, 2, 1, 1'b0, 0, -1, -1, 1'b0);  // unsigned 2x3, two words
        run_job(3, 3, 0, 1'b1, 0, -1, -1, 1'b0);  // signed 4x4
        run_job(1, 1, 1, 1'b0, 2, 3, -1, 1'b0);   // stall burst on word_last of word 0
        run_job(0, 0, 3, 1'b0, 0, -1, -1, 1'b0);  // 1x1, four words
        run_job(0, 0, 1, 1'b1, 0, -1, -1, 1'b0);  // signed 1x1: sign*sign is positive
        run_job(1, 1, 1, 1'b0, 0, -1, 7, 1'b0);   // abort on the final word_last

        // Abort while idle is ignored.
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_in_idle", bus.ready, 1);

        // start held through two back-to-back jobs.
        run_job(2, 1, 1, 1'b1, 0, -1, -1, 1'b1);
        run_job(1, 2, 0, 1'b0, 1, -1, -1, 1'b1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("no_restart_after_hold", bus.ready, 1);

        for (int i = 0; i < 20; i++) begin
            ap    = int'($urandom_range(15));
            wp    = int'($urandom_range(15));
            n     = int'($urandom_range(2));
            pairs = (ap + 1) * (wp + 1) * (n + 1);
            ab    = ($urandom_range(3) == 0) ? int'($urandom_range(pairs - 1)) : -1;
            run_job(ap, wp, n, 1'($urandom), 1, -1, ab, 1'b0);
        end

        // Asynchronous reset in the middle of a word.
        bus.start       = 1'b1;
        bus.a_prec_m1   = 4'd3;
        bus.w_prec_m1   = 4'd3;
        bus.nwords_m1   = 8'd0;
        bus.signed_mode = 1'b1;
        push_job(3, 3, 0, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", bus.ready, 1);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_strobes", {bus.acc_en, bus.acc_clr, bus.neg, bus.word_last}, 0);
        chk("async_rst_idx", {bus.a_idx, bus.w_idx, bus.shift_amt}, 0);
        chk("async_rst_flags", {bus.out_valid, bus.done}, 0);
        rst_epoch++;
        pair_q.delete();
        word_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_idle", bus.ready, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("pairs_drained", pair_q.size(), 0);
        chk("words_drained", word_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
